oam_dma_bus_arbiter: RTL and testbench
======================================

Name: oam_dma_bus_arbiter

Overview:
Owns the shared memory bus in front of the BRAM wrappers and arbitrates it between the CPU and the OAM DMA engine.
- Idle: CPU accesses pass straight through to the memory bus.
- A CPU write to the DMA register starts a 160-byte copy from {src,8'h00} to 0xFE00. During the copy the engine owns the bus and the CPU is locked out.
- Sits between the CPU bus interface and the memory router / BRAM wrappers.

Parameters:
P_DMA_REG_ADDR, 16'hFF46, CPU address of the DMA source register
P_DEST_BASE, 16'hFE00, first OAM destination address
P_LENGTH, 160, bytes per transfer (1..256)

Ports:
I_CLK  input  1  system clock
I_RESET  input  1  reset; asynchronous, active-high
I_CPU_ADDR  input  16  CPU address
I_CPU_DIN  input  8  CPU write data
O_CPU_DOUT  output  8  CPU read data
I_CPU_WE_L  input  1  CPU write strobe, active-low
I_CPU_RE_L  input  1  CPU read strobe, active-low
O_MEM_ADDR  output  16  memory bus address
O_MEM_WDATA  output  8  memory bus write data
I_MEM_RDATA  input  8  memory bus read data; valid one cycle after O_MEM_RE_L low
O_MEM_WE_L  output  1  memory write strobe, active-low
O_MEM_RE_L  output  1  memory read strobe, active-low
O_DMA_ACTIVE  output  1  high while the DMA owns the bus
O_DMA_DONE  output  1  one-cycle pulse after the final write

Behaviour:
- Clock and reset: single clock I_CLK. I_RESET is asynchronous, active-high.
- Reset state: IDLE, src_reg=8'h00, index=0, we_l_d=1.
  - O_DMA_ACTIVE=0 and O_DMA_DONE=0.
  - Memory outputs mirror the CPU inputs (pass-through).
- States: IDLE, START, READ, WRITE.
- Trigger:
  - Fires in the cycle where I_CPU_WE_L=0, we_l_d=1 (registered previous WE_L) and I_CPU_ADDR==P_DMA_REG_ADDR.
  - On the next edge: src_reg<=I_CPU_DIN, index<=0, state<=START.
  - A held-low WE_L triggers only once.
- Source clamp: effective source high byte = src_reg - 8'h20 when src_reg > 8'hDF (echo region), otherwise src_reg.
- IDLE, pass-through:
  - O_MEM_ADDR=I_CPU_ADDR, O_MEM_WDATA=I_CPU_DIN, O_MEM_WE_L=I_CPU_WE_L, O_MEM_RE_L=I_CPU_RE_L.
  - O_CPU_DOUT=I_MEM_RDATA.
- DMA register access: a CPU read of P_DMA_REG_ADDR returns src_reg in any state. The trigger write is also forwarded to memory in IDLE; this is harmless.
- START: one handoff cycle.
  - O_DMA_ACTIVE=1, O_MEM_WE_L=1, O_MEM_RE_L=1.
  - Next state: READ.
- READ:
  - O_MEM_ADDR={src_eff,index}, O_MEM_RE_L=0, O_MEM_WE_L=1.
  - Next state: WRITE.
- WRITE:
  - O_MEM_ADDR=P_DEST_BASE+index, O_MEM_WE_L=0, O_MEM_RE_L=1, O_MEM_WDATA=I_MEM_RDATA.
  - If index==P_LENGTH-1: go to IDLE and pulse O_DMA_DONE for the following cycle.
  - Else: index<=index+1 and go to READ.
- Timing:
  - Busy time is 1+2*P_LENGTH cycles (321 at default).
  - O_DMA_ACTIVE is high exactly in START/READ/WRITE.
  - First pass-through cycle is the cycle after the final WRITE.
- CPU during DMA (O_DMA_ACTIVE=1):
  - CPU strobes are never forwarded to memory.
  - O_CPU_DOUT=8'hFF, except reads of P_DMA_REG_ADDR.
  - CPU writes are dropped, except a new trigger.
- Retrigger mid-transfer: a trigger seen in any DMA state loads the new src_reg, resets index to 0 and goes to START. The aborted transfer produces no DONE pulse.
- Width rules:
  - index is 8 bits; destination = P_DEST_BASE + zero-extended index, 16-bit.
  - Source low byte = index, so no carry into the high byte.
- Reset mid-transfer: immediate return to reset state. No further memory strobes. No DONE pulse.

Test Plan:
- Idle pass-through: CPU read 0xC123 with I_MEM_RDATA=8'h5A -> O_MEM_ADDR=0xC123, O_MEM_RE_L=0, O_CPU_DOUT=8'h5A; CPU write 0xC000=8'h11 -> O_MEM_WE_L=0, O_MEM_WDATA=8'h11.
- Full DMA: write 8'hC1 to 0xFF46 against a memory model holding byte i at 0xC100+i:
  - reads 0xC100..0xC19F are issued.
  - writes to 0xFE00..0xFE9F carry the matching data.
  - O_DMA_ACTIVE is high for exactly 321 cycles and O_DMA_DONE pulses once.
- Lockout: during DMA, CPU read 0xC000 -> O_CPU_DOUT=8'hFF and no CPU-driven memory strobe; read 0xFF46 -> 8'hC1.
- Echo clamp: write 8'hE3 -> reads start at 0xC300.
- Retrigger: at index 50, write 8'hD0 -> index restarts at 0, reads come from 0xD000, a single DONE pulse follows, and 321 cycles elapse from the retrigger.
- Async reset: assert I_RESET in a WRITE cycle -> O_DMA_ACTIVE=0 and pass-through resume immediately, with no DONE pulse; a WE_L held low across a trigger starts only one DMA.

Source files
------------

// File: rtl/oam_dma_bus_arbiter.sv
// oam_dma_bus_arbiter
// Owns the shared memory bus in front of the BRAM wrappers. CPU accesses pass
// straight through while idle. A CPU write to the DMA source register starts
// a byte-by-byte copy of one source page into OAM. The CPU is locked out of
// the bus for the whole copy.

module oam_dma_bus_arbiter #(
    parameter logic [15:0] P_DMA_REG_ADDR = 16'hFF46,
    parameter logic [15:0] P_DEST_BASE    = 16'hFE00,
    parameter int          P_LENGTH       = 160
) (
    input  logic        I_CLK,
    input  logic        I_RESET,
    input  logic [15:0] I_CPU_ADDR,
    input  logic [7:0]  I_CPU_DIN,
    output logic [7:0]  O_CPU_DOUT,
    input  logic        I_CPU_WE_L,
    input  logic        I_CPU_RE_L,
    output logic [15:0] O_MEM_ADDR,
    output logic [7:0]  O_MEM_WDATA,
    input  logic [7:0]  I_MEM_RDATA,
    output logic        O_MEM_WE_L,
    output logic        O_MEM_RE_L,
    output logic        O_DMA_ACTIVE,
    output logic        O_DMA_DONE
);

    localparam logic [7:0] LAST_INDEX = 8'(P_LENGTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        READ,
        WRITE
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [7:0]  src_reg;
    logic [7:0]  src_eff;
    logic [7:0]  index;
    logic        we_l_d;
    logic        done_q;
    logic        trigger;
    logic        last_write;

    // Only the falling edge of WE_L on the register address starts a copy,
    // so a strobe held low across several cycles triggers exactly once.
    assign trigger    = ~I_CPU_WE_L & we_l_d & (I_CPU_ADDR == P_DMA_REG_ADDR);

    // Sources in the echo region are folded back onto the work RAM they mirror.
    assign src_eff    = (src_reg > 8'hDF) ? (src_reg - 8'h20) : src_reg;

    assign last_write = (state == WRITE) && (index == LAST_INDEX);

    assign O_DMA_DONE = done_q;

    // State, source register, byte index, strobe history and done pulse.
    always_ff @(posedge I_CLK or posedge I_RESET) begin
        if (I_RESET) begin
            state   <= IDLE;
            src_reg <= 8'h00;
            index   <= 8'h00;
            we_l_d  <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state   <= state_next;
            we_l_d  <= I_CPU_WE_L;
            done_q  <= last_write & ~trigger;
            if (trigger) begin
                src_reg <= I_CPU_DIN;
                index   <= 8'h00;
            end else if ((state == WRITE) && !last_write) begin
                index   <= index + 8'h01;
            end
        end
    end

    // Next-state sequencing; a new trigger restarts the copy from any state.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = IDLE;
            START:   state_next = READ;
            READ:    state_next = WRITE;
            WRITE:   state_next = last_write ? IDLE : READ;
            default: state_next = IDLE;
        endcase
        if (trigger) begin
            state_next = START;
        end
    end

    // Bus ownership: pass-through when idle, engine-driven strobes otherwise.
    always_comb begin
        O_MEM_ADDR   = I_CPU_ADDR;
        O_MEM_WDATA  = I_CPU_DIN;
        O_MEM_WE_L   = I_CPU_WE_L;
        O_MEM_RE_L   = I_CPU_RE_L;
        O_DMA_ACTIVE = 1'b0;
        case (state)
            START: begin
                O_DMA_ACTIVE = 1'b1;
                O_MEM_ADDR   = {src_eff, index};
                O_MEM_WDATA  = 8'h00;
                O_MEM_WE_L   = 1'b1;
                O_MEM_RE_L   = 1'b1;
            end
            READ: begin
                O_DMA_ACTIVE = 1'b1;
                O_MEM_ADDR   = {src_eff, index};
                O_MEM_WDATA  = 8'h00;
                O_MEM_WE_L   = 1'b1;
                O_MEM_RE_L   = 1'b0;
            end
            WRITE: begin
                O_DMA_ACTIVE = 1'b1;
                O_MEM_ADDR   = P_DEST_BASE + {8'h00, index};
                O_MEM_WDATA  = I_MEM_RDATA;
                O_MEM_WE_L   = 1'b0;
                O_MEM_RE_L   = 1'b1;
            end
            default: begin
                O_DMA_ACTIVE = 1'b0;
            end
        endcase
    end

    // CPU read data: the DMA register is always readable, everything else
    // reads as open bus while the engine owns memory.
    always_comb begin
        O_CPU_DOUT = I_MEM_RDATA;
        if (!I_CPU_RE_L && (I_CPU_ADDR == P_DMA_REG_ADDR)) begin
            O_CPU_DOUT = src_reg;
        end else if (O_DMA_ACTIVE) begin
            O_CPU_DOUT = 8'hFF;
        end
    end

endmodule

// File: tb/tb_oam_dma_bus_arbiter.sv
// tb_oam_dma_bus_arbiter
// Directed bench for the OAM DMA bus arbiter. A small synchronous memory model
// answers reads, and every expected DMA bus operation is queued when a copy is
// started and checked as the arbiter issues it.

module tb_oam_dma_bus_arbiter;

    logic        I_CLK;
    logic        I_RESET;
    logic [15:0] I_CPU_ADDR;
    logic [7:0]  I_CPU_DIN;
    logic [7:0]  O_CPU_DOUT;
    logic        I_CPU_WE_L;
    logic        I_CPU_RE_L;
    logic [15:0] O_MEM_ADDR;
    logic [7:0]  O_MEM_WDATA;
    logic [7:0]  I_MEM_RDATA;
    logic        O_MEM_WE_L;
    logic        O_MEM_RE_L;
    logic        O_DMA_ACTIVE;
    logic        O_DMA_DONE;

    typedef struct packed {
        logic        wr;
        logic [15:0] addr;
        logic [7:0]  data;
    } op_t;

    op_t  exp_q[$];
    int   compared   = 0;
    int   mismatched = 0;
    int   ops_seen   = 0;
    int   active_cycles = 0;
    int   done_count = 0;
    bit   mon_en     = 1'b1;

    logic [7:0] model_rdata;
    logic [7:0] forced_rdata;
    bit         use_forced;

    assign I_MEM_RDATA = use_forced ? forced_rdata : model_rdata;

    oam_dma_bus_arbiter dut (
        .I_CLK        (I_CLK),
        .I_RESET      (I_RESET),
        .I_CPU_ADDR   (I_CPU_ADDR),
        .I_CPU_DIN    (I_CPU_DIN),
        .O_CPU_DOUT   (O_CPU_DOUT),
        .I_CPU_WE_L   (I_CPU_WE_L),
        .I_CPU_RE_L   (I_CPU_RE_L),
        .O_MEM_ADDR   (O_MEM_ADDR),
        .O_MEM_WDATA  (O_MEM_WDATA),
        .I_MEM_RDATA  (I_MEM_RDATA),
        .O_MEM_WE_L   (O_MEM_WE_L),
        .O_MEM_RE_L   (O_MEM_RE_L),
        .O_DMA_ACTIVE (O_DMA_ACTIVE),
        .O_DMA_DONE   (O_DMA_DONE)
    );

    initial I_CLK = 1'b0;
    always #5 I_CLK = ~I_CLK;

    function automatic logic [7:0] model_byte(input logic [15:0] a);
        return a[7:0] ^ a[15:8];
    endfunction

    // Memory model: read data is valid the cycle after the read strobe.
    always @(posedge I_CLK) begin
        if (!O_MEM_RE_L) model_rdata <= model_byte(O_MEM_ADDR);
    end

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Monitor: counts busy cycles and done pulses, and matches DMA bus ops
    // against the queued expectations.
    always @(negedge I_CLK) begin
        op_t obs;
        op_t exp_op;
        if (O_DMA_DONE) done_count++;
        if (O_DMA_ACTIVE) active_cycles++;
        if (mon_en && O_DMA_ACTIVE && (!O_MEM_RE_L || !O_MEM_WE_L)) begin
            obs.wr   = ~O_MEM_WE_L;
            obs.addr = O_MEM_ADDR;
            obs.data = (~O_MEM_WE_L) ? O_MEM_WDATA : 8'h00;
            if (exp_q.size() == 0) begin
                check_output("unexpected_dma_op", 32'(obs), 32'h1FFFFFF);
            end else begin
                exp_op = exp_q.pop_front();
                check_output("dma_op", 32'(obs), 32'(exp_op));
            end
            ops_seen++;
        end
    end

    task automatic push_dma(input logic [7:0] src);
        logic [7:0] eff;
        op_t o;
        eff = (src > 8'hDF) ? src - 8'h20 : src;
        for (int i = 0; i < 160; i++) begin
            o.wr = 1'b0; o.addr = {eff, 8'(i)}; o.data = 8'h00;
            exp_q.push_back(o);
            o.wr = 1'b1; o.addr = 16'hFE00 + 16'(i); o.data = model_byte({eff, 8'(i)});
            exp_q.push_back(o);
        end
    endtask

    task automatic cpu_idle();
        I_CPU_WE_L = 1'b1;
        I_CPU_RE_L = 1'b1;
        I_CPU_ADDR = 16'h0000;
        I_CPU_DIN  = 8'h00;
    endtask

    task automatic apply_stimulus(input logic [7:0] src);
        exp_q.delete();
        push_dma(src);
        ops_seen = 0;
        active_cycles = 0;
        @(posedge I_CLK); #1;
        I_CPU_ADDR = 16'hFF46; I_CPU_DIN = src; I_CPU_WE_L = 1'b0;
        @(posedge I_CLK); #1;
        cpu_idle();
    endtask

    task automatic wait_ops(input int n);
        int cyc = 0;
        while (ops_seen != n && cyc < 1000) begin
            @(posedge I_CLK);
            cyc++;
        end
        #1;
        check_output("wait_ops_reached", 32'(ops_seen), 32'(n));
    endtask

    task automatic wait_done(input int base, input string tag);
        int cyc = 0;
        while (done_count == base && cyc < 600) begin
            @(posedge I_CLK);
            cyc++;
        end
        repeat (3) @(posedge I_CLK);
        #1;
        check_output({tag, "_done_pulses"}, 32'(done_count - base), 32'd1);
        check_output({tag, "_active_cycles"}, 32'(active_cycles), 32'd321);
        check_output({tag, "_queue_left"}, 32'(exp_q.size()), 32'd0);
        check_output({tag, "_inactive_after"}, 32'(O_DMA_ACTIVE), 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int base;
        use_forced   = 1'b0;
        forced_rdata = 8'h00;
        I_RESET      = 1'b1;
        cpu_idle();
        I_CPU_ADDR = 16'h1234;
        #12;
        check_output("reset_active", 32'(O_DMA_ACTIVE), 32'd0);
        check_output("reset_done", 32'(O_DMA_DONE), 32'd0);
        check_output("reset_passthru_addr", 32'(O_MEM_ADDR), 32'h1234);
        I_CPU_ADDR = 16'hFF46; I_CPU_RE_L = 1'b0;
        #1;
        check_output("reset_src_reg", 32'(O_CPU_DOUT), 32'h00);
        cpu_idle();
        @(negedge I_CLK);
        I_RESET = 1'b0;

        // Idle pass-through read and write
        @(posedge I_CLK); #1;
        use_forced = 1'b1; forced_rdata = 8'h5A;
        I_CPU_ADDR = 16'hC123; I_CPU_RE_L = 1'b0;
        #1;
        check_output("idle_rd_addr", 32'(O_MEM_ADDR), 32'hC123);
        check_output("idle_rd_re", 32'(O_MEM_RE_L), 32'd0);
        check_output("idle_rd_dout", 32'(O_CPU_DOUT), 32'h5A);
        I_CPU_RE_L = 1'b1; I_CPU_ADDR = 16'hC000; I_CPU_DIN = 8'h11; I_CPU_WE_L = 1'b0;
        #1;
        check_output("idle_wr_we", 32'(O_MEM_WE_L), 32'd0);
        check_output("idle_wr_addr", 32'(O_MEM_ADDR), 32'hC000);
        check_output("idle_wr_data", 32'(O_MEM_WDATA), 32'h11);
        @(posedge I_CLK); #1;
        cpu_idle();
        use_forced = 1'b0;

        // Full copy from page C1 with a CPU lockout probe in the middle
        base = done_count;
        apply_stimulus(8'hC1);
        wait_ops(40);
        I_CPU_ADDR = 16'hC000; I_CPU_RE_L = 1'b0;
        #1;
        check_output("lock_rd_dout", 32'(O_CPU_DOUT), 32'hFF);
        check_output("lock_dma_addr", 32'(O_MEM_ADDR), 32'hC114);
        @(posedge I_CLK); #1;
        check_output("lock_no_cpu_re", 32'(O_MEM_RE_L), 32'd1);
        check_output("lock_rd_dout2", 32'(O_CPU_DOUT), 32'hFF);
        I_CPU_ADDR = 16'hFF46;
        #1;
        check_output("lock_reg_read", 32'(O_CPU_DOUT), 32'hC1);
        cpu_idle();
        wait_done(base, "full");

        // Echo region source folds down onto work RAM
        base = done_count;
        apply_stimulus(8'hE3);
        wait_done(base, "echo");

        // Retrigger part-way through a copy
        base = done_count;
        apply_stimulus(8'hC1);
        wait_ops(100);
        I_CPU_ADDR = 16'hFF46; I_CPU_DIN = 8'hD0; I_CPU_WE_L = 1'b0;
        @(posedge I_CLK); #1;
        cpu_idle();
        exp_q.delete();
        push_dma(8'hD0);
        ops_seen = 0;
        active_cycles = 0;
        wait_done(base, "retrig");

        // Asynchronous reset during a write cycle
        base = done_count;
        apply_stimulus(8'hC1);
        wait_ops(21);
        check_output("rst_in_write", 32'(O_MEM_WE_L), 32'd0);
        mon_en = 1'b0;
        I_CPU_ADDR = 16'hC000; I_CPU_RE_L = 1'b0;
        I_RESET = 1'b1;
        #1;
        check_output("rst_active", 32'(O_DMA_ACTIVE), 32'd0);
        check_output("rst_passthru_addr", 32'(O_MEM_ADDR), 32'hC000);
        check_output("rst_passthru_re", 32'(O_MEM_RE_L), 32'd0);
        check_output("rst_no_we", 32'(O_MEM_WE_L), 32'd1);
        repeat (2) @(posedge I_CLK);
        #1;
        I_RESET = 1'b0;
        exp_q.delete();
        repeat (5) @(posedge I_CLK);
        #1;
        check_output("rst_no_done", 32'(done_count - base), 32'd0);
        I_CPU_ADDR = 16'hFF46;
        #1;
        check_output("rst_src_cleared", 32'(O_CPU_DOUT), 32'h00);
        cpu_idle();
        mon_en = 1'b1;

        // WE_L held low across the trigger starts a single copy
        base = done_count;
        exp_q.delete();
        push_dma(8'hC1);
        ops_seen = 0;
        active_cycles = 0;
        @(posedge I_CLK); #1;
        I_CPU_ADDR = 16'hFF46; I_CPU_DIN = 8'hC1; I_CPU_WE_L = 1'b0;
        repeat (12) @(posedge I_CLK);
        #1;
        cpu_idle();
        wait_done(base, "held_we");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
